// File: rtl/apb3_exti_pkg.sv
// Shared peripheral definitions: EXTI register map and the APB3 slave bundle
// also used by the GPIO ports.
package apb3_exti_pkg;

  localparam int EXTI_LINES_MAX = 16;
  localparam int APB_AW         = 3;
  localparam int APB_DW         = 32;

  typedef enum logic [APB_AW-1:0] {
    EXTI_IMR   = 3'd0,
    EXTI_EMR   = 3'd1,
    EXTI_RTSR  = 3'd2,
    EXTI_FTSR  = 3'd3,
    EXTI_SWIER = 3'd4,
    EXTI_PR    = 3'd5,
    EXTI_RSV6  = 3'd6,
    EXTI_RSV7  = 3'd7
  } exti_idx_e;

  typedef struct packed {
    logic [APB_AW-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_DW-1:0] pwdata;
  } apb_req_t;

  typedef struct packed {
    logic              pready;
    logic [APB_DW-1:0] prdata;
    logic              pslverror;
  } apb_rsp_t;

  // Indices 6 and 7 are unmapped and answer with a slave error.
  function automatic logic exti_idx_err(input logic [APB_AW-1:0] idx);
    return idx >= EXTI_RSV6;
  endfunction

endpackage

// File: rtl/apb3_exti_if.sv
// APB3 slave bundle, word-indexed, shared by the peripheral router.
interface apb3_exti_if;
  import apb3_exti_pkg::*;

  logic [APB_AW-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PWDATA;
  logic              PREADY;
  logic [APB_DW-1:0] PRDATA;
  logic              PSLVERROR;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERROR
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERROR
  );
endinterface

// File: rtl/apb3_exti_edge_sync.sv
// WIDTH-wide 3-flop synchroniser with rise/fall detection on the settled stages.
// Also used by timer capture inputs.
module exti_edge_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 may be metastable; edges are judged only between s2 and s3.
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/apb3_exti.sv
// APB3 external-interrupt controller: masks, edge selects, pending flags,
// software trigger, per-line IRQs and a one-cycle event pulse.
module apb3_exti
  import apb3_exti_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic             io_apb_PCLK,
  input  logic             io_apb_PRESET,
  apb3_exti_if.slave       io_apb,
  input  logic [LINES-1:0] pin_i,
  output logic [LINES-1:0] irq_o,
  output logic             irq_any_o,
  output logic             evt_o
);

  apb_req_t  req;
  apb_rsp_t  rsp;
  exti_idx_e idx;

  logic             acc, err, wr, rd;
  logic [LINES-1:0] wdat;
  logic [LINES-1:0] imr, emr, rtsr, ftsr, pr;
  logic [LINES-1:0] rise, fall, hit, clr, swi, pr_nxt;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             unused_pwdata;

  assign req = '{paddr:   io_apb.PADDR,
                 psel:    io_apb.PSEL,
                 penable: io_apb.PENABLE,
                 pwrite:  io_apb.PWRITE,
                 pwdata:  io_apb.PWDATA};

  assign idx  = exti_idx_e'(req.paddr);
  assign acc  = req.psel & req.penable;
  assign err  = acc & exti_idx_err(req.paddr);
  assign wr   = acc & req.pwrite & ~err;
  assign rd   = acc & ~req.pwrite & ~err;
  assign wdat = req.pwdata[LINES-1:0];

  assign unused_pwdata = ^req.pwdata[APB_DW-1:LINES];

  exti_edge_sync #(.WIDTH(LINES)) u_sync (
    .clk  (io_apb_PCLK),
    .rst  (io_apb_PRESET),
    .d    (pin_i),
    .rise (rise),
    .fall (fall)
  );

  // Edges are ignored until the synchroniser has been refilled after reset.
  assign armed = (arm_cnt == 2'd3);
  assign hit   = {LINES{armed}} & ((rise & rtsr) | (fall & ftsr));

  assign clr    = (wr && idx == EXTI_PR)    ? wdat : '0;
  assign swi    = (wr && idx == EXTI_SWIER) ? wdat : '0;
  assign pr_nxt = (pr & ~clr) | hit | swi;

  always_ff @(posedge io_apb_PCLK) begin
    if (io_apb_PRESET) begin
      imr       <= '0;
      emr       <= '0;
      rtsr      <= '0;
      ftsr      <= '0;
      pr        <= '0;
      arm_cnt   <= '0;
      irq_o     <= '0;
      irq_any_o <= 1'b0;
      evt_o     <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      if (wr) begin
        case (idx)
          EXTI_IMR:  imr  <= wdat;
          EXTI_EMR:  emr  <= wdat;
          EXTI_RTSR: rtsr <= wdat;
          EXTI_FTSR: ftsr <= wdat;
          default:   ;
        endcase
      end
      pr        <= pr_nxt;
      irq_o     <= pr_nxt & imr;
      irq_any_o <= |(pr_nxt & imr);
      // Events come from raw edges only; pending state and IMR play no part.
      evt_o     <= |(hit & emr);
    end
  end

  always_comb begin
    rsp           = '0;
    rsp.pready    = 1'b1;
    rsp.pslverror = err;
    if (rd) begin
      case (idx)
        EXTI_IMR:  rsp.prdata = APB_DW'(imr);
        EXTI_EMR:  rsp.prdata = APB_DW'(emr);
        EXTI_RTSR: rsp.prdata = APB_DW'(rtsr);
        EXTI_FTSR: rsp.prdata = APB_DW'(ftsr);
        EXTI_PR:   rsp.prdata = APB_DW'(pr);
        default:   rsp.prdata = '0;
      endcase
    end
  end

  assign io_apb.PREADY    = rsp.pready;
  assign io_apb.PRDATA    = rsp.prdata;
  assign io_apb.PSLVERROR = rsp.pslverror;

endmodule

// File: tb/tb_apb3_exti.sv
// Directed bench for apb3_exti; expectations are queued by the stimulus and
// checked by a negedge monitor.
module tb_apb3_exti;
  import apb3_exti_pkg::*;

  localparam int LINES = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LINES-1:0] pin;
  logic [LINES-1:0] irq;
  logic             irq_any, evt;

  apb3_exti_if bus ();

  apb3_exti #(.LINES(LINES)) dut (
    .io_apb_PCLK   (clk),
    .io_apb_PRESET (rst),
    .io_apb        (bus),
    .pin_i         (pin),
    .irq_o         (irq),
    .irq_any_o     (irq_any),
    .evt_o         (evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } acc_exp_t;

  typedef struct {
    string       name;
    int          cyc;
    int          sig;   // 0 irq_o, 1 irq_any_o, 2 evt_o
    logic [31:0] val;
  } out_exp_t;

  acc_exp_t aq[$];
  out_exp_t tq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every APB access phase pops one bus expectation; timed output
  // expectations are compared on the cycle they name.
  always @(negedge clk) begin
    acc_exp_t    e;
    logic [31:0] act;
    if (bus.PSEL && bus.PENABLE) begin
      if (aq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access: got access idx %0d expected none", bus.PADDR);
      end else begin
        e = aq.pop_front();
        chk({e.name, ".prdata"}, bus.PRDATA, e.rdata);
        chk({e.name, ".pslverr"}, 32'(bus.PSLVERROR), 32'(e.err));
        chk({e.name, ".pready"}, 32'(bus.PREADY), 32'd1);
      end
    end
    for (int i = tq.size() - 1; i >= 0; i--) begin
      if (tq[i].cyc <= cyc) begin
        case (tq[i].sig)
          0:       act = 32'(irq);
          1:       act = 32'(irq_any);
          default: act = 32'(evt);
        endcase
        if (tq[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s: got no sample expected check at cycle %0d", tq[i].name, tq[i].cyc);
        end else begin
          chk(tq[i].name, act, tq[i].val);
        end
        tq.delete(i);
      end
    end
  end

  task automatic expect_out(input string name, input int c, input int sig, input logic [31:0] v);
    tq.push_back('{name, c, sig, v});
  endtask

  task automatic apb(input logic wr, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input string name);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    aq.push_back('{name, exp_rd, exti_idx_err(a)});
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input string name);
    apb(1'b1, a, d, 32'h0, name);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    apb(1'b0, a, 32'h0, exp, name);
  endtask

  task automatic set_pin(input int i, input logic v, output int k);
    @(posedge clk); #1;
    pin[i] = v;
    k = cyc;
  endtask

  // Release reset with an RTSR=all-ones write already in setup, so the write
  // lands while the synchroniser still shows a rise on every high pin.
  task automatic release_with_rtsr(input string name);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = EXTI_RTSR; bus.PWDATA = 32'h0000_FFFF;
    aq.push_back('{{name, "_rtsr"}, 32'h0, 1'b0});
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    expect_out({name, "_irq"}, cyc + 1, 0, 32'h0);
    expect_out({name, "_evt"}, cyc + 1, 2, 32'h0);
    rd(EXTI_PR, 32'h0, {name, "_pr"});
  endtask

  initial begin
    int k, c;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    pin = '1;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    expect_out("rst_irq", cyc, 0, 32'h0);
    expect_out("rst_irq_any", cyc, 1, 32'h0);
    expect_out("rst_evt", cyc, 2, 32'h0);

    release_with_rtsr("arm");
    rd(EXTI_RTSR, 32'h0000_FFFF, "rtsr_rd");

    // Rising edge on line 0
    wr(EXTI_RTSR, 32'h0001, "rtsr0");
    wr(EXTI_IMR, 32'h0001, "imr0");
    set_pin(0, 1'b0, k);
    repeat (4) @(posedge clk);
    set_pin(0, 1'b1, k);
    expect_out("rise0_irq_early", k + 2, 0, 32'h0);
    expect_out("rise0_irq", k + 3, 0, 32'h0001);
    expect_out("rise0_irq_any", k + 3, 1, 32'h1);
    repeat (4) @(posedge clk);
    rd(EXTI_PR, 32'h0001, "rise0_pr");
    wr(EXTI_PR, 32'h0001, "clr0");
    expect_out("clr0_irq", cyc, 0, 32'h0);
    rd(EXTI_PR, 32'h0, "clr0_pr");

    // Falling edge on line 15 with event enabled, interrupt masked
    wr(EXTI_FTSR, 32'h8000, "ftsr15");
    wr(EXTI_EMR, 32'h8000, "emr15");
    wr(EXTI_IMR, 32'h0, "imr_off");
    set_pin(15, 1'b0, k);
    expect_out("fall15_evt_pre", k + 2, 2, 32'h0);
    expect_out("fall15_evt", k + 3, 2, 32'h1);
    expect_out("fall15_evt_post", k + 4, 2, 32'h0);
    expect_out("fall15_irq_masked", k + 3, 0, 32'h0);
    repeat (5) @(posedge clk);
    rd(EXTI_PR, 32'h8000, "fall15_pr");
    wr(EXTI_IMR, 32'h8000, "imr15");
    c = cyc;
    expect_out("imr15_irq_same", c, 0, 32'h0);
    expect_out("imr15_irq", c + 1, 0, 32'h8000);
    expect_out("imr15_irq_any", c + 1, 1, 32'h1);
    repeat (2) @(posedge clk);

    // Clear of PR[3] on the same edge as a new rise on line 3
    wr(EXTI_RTSR, 32'h0008, "rtsr3");
    set_pin(3, 1'b0, k);
    repeat (4) @(posedge clk);
    set_pin(3, 1'b1, k);
    repeat (4) @(posedge clk);
    rd(EXTI_PR, 32'h8008, "pr3_set");
    set_pin(3, 1'b0, k);
    repeat (4) @(posedge clk);
    set_pin(3, 1'b1, k);
    wr(EXTI_PR, 32'h0008, "pr3_race_clr");
    rd(EXTI_PR, 32'h8008, "pr3_race");
    wr(EXTI_PR, 32'h0008, "pr3_clr");
    rd(EXTI_PR, 32'h8000, "pr3_cleared");

    // Software trigger
    wr(EXTI_IMR, 32'hFFFF_FFFF, "imr_all");
    wr(EXTI_EMR, 32'h0000_FFFF, "emr_all");
    wr(EXTI_PR, 32'h0000_FFFF, "pr_clr_all");
    expect_out("pr_clr_all_irq", cyc, 0, 32'h0);
    wr(EXTI_SWIER, 32'h0024, "swier");
    expect_out("swier_irq", cyc, 0, 32'h0024);
    expect_out("swier_irq_any", cyc, 1, 32'h1);
    expect_out("swier_evt", cyc, 2, 32'h0);
    expect_out("swier_evt_next", cyc + 1, 2, 32'h0);
    rd(EXTI_PR, 32'h0024, "swier_pr");
    rd(EXTI_SWIER, 32'h0, "swier_rd");

    // Unmapped indices
    rd(3'd6, 32'h0, "idx6_rd");
    rd(3'd7, 32'h0, "idx7_rd");
    wr(3'd7, 32'hFFFF_FFFF, "idx7_wr");
    rd(EXTI_IMR, 32'h0000_FFFF, "post7_imr");
    rd(EXTI_EMR, 32'h0000_FFFF, "post7_emr");
    rd(EXTI_RTSR, 32'h0008, "post7_rtsr");
    rd(EXTI_FTSR, 32'h8000, "post7_ftsr");
    rd(EXTI_PR, 32'h0024, "post7_pr");

    // Reset in the middle of a SWIER access phase
    @(posedge clk); #1;
    rst = 1'b1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
    bus.PADDR = EXTI_SWIER; bus.PWDATA = 32'h0000_FFFF;
    aq.push_back('{"midrst_acc", 32'h0, 1'b0});
    expect_out("midrst_irq_before", cyc, 0, 32'h0024);
    expect_out("midrst_irq", cyc + 1, 0, 32'h0);
    expect_out("midrst_irq_any", cyc + 1, 1, 32'h0);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    release_with_rtsr("rearm");
    rd(EXTI_IMR, 32'h0, "rearm_imr");

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (aq.size() != 0 || tq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d bus and %0d output expectations pending expected 0",
               aq.size(), tq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
